// File: rtl/rv_pkg.sv
// Shared core-level types used by the execute-stage blocks.
package rv_pkg;

    // Operation select for the shared integer ALU
    typedef enum logic [3:0] {
        ALU_CTRL_ADD  = 4'd0,
        ALU_CTRL_SUB  = 4'd1,
        ALU_CTRL_AND  = 4'd2,
        ALU_CTRL_OR   = 4'd3,
        ALU_CTRL_XOR  = 4'd4,
        ALU_CTRL_SLL  = 4'd5,
        ALU_CTRL_SRL  = 4'd6,
        ALU_CTRL_SRA  = 4'd7,
        ALU_CTRL_SLT  = 4'd8,
        ALU_CTRL_SLTU = 4'd9
    } alu_ctrl_e;

endpackage

// File: rtl/rv_div_seq.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU). All arithmetic is
// done by the shared ALU (always subtracting); this block only sequences it,
// detects borrow from MSBs and handles divide-by-zero / signed overflow.
module rv_div_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [1:0]          i_op,
    input  logic [XLEN-1:0]     i_dividend,
    input  logic [XLEN-1:0]     i_divisor,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_done,
    output logic [XLEN-1:0]     o_res,
    output logic [XLEN-1:0]     o_alu_a,
    output logic [XLEN-1:0]     o_alu_b,
    output rv_pkg::alu_ctrl_e   o_alu_ctrl,
    input  logic [XLEN-1:0]     i_alu_res
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS_A = 3'd1,
        ST_ABS_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    quo_q, quo_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               na_q, na_d;
    logic               nb_q, nb_d;
    logic               is_rem_q, is_rem_d;
    logic [XLEN-1:0]    res_d;

    logic               sgn, dz, ovf;
    logic [XLEN-1:0]    sh, fix_val;
    logic               borrow, take, fix_neg;

    assign o_alu_ctrl = rv_pkg::ALU_CTRL_SUB;

    // Next-state, ALU operand steering and datapath next values
    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        na_d     = na_q;
        nb_d     = nb_q;
        is_rem_d = is_rem_q;
        res_d    = o_res;
        o_alu_a  = '0;
        o_alu_b  = '0;
        sgn      = 1'b0;
        dz       = 1'b0;
        ovf      = 1'b0;
        sh       = '0;
        borrow   = 1'b0;
        take     = 1'b0;
        fix_val  = '0;
        fix_neg  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_flush) begin
                    sgn      = ~i_op[0];
                    dz       = (i_divisor == '0);
                    ovf      = sgn && (i_dividend == MIN_NEG) && (i_divisor == '1);
                    quo_d    = i_dividend;
                    dvs_d    = i_divisor;
                    na_d     = sgn & i_dividend[XLEN-1];
                    nb_d     = sgn & i_divisor[XLEN-1];
                    is_rem_d = i_op[1];
                    if (dz) begin
                        res_d   = i_op[1] ? i_dividend : '1;
                        state_d = ST_DONE;
                    end else if (ovf) begin
                        res_d   = i_op[1] ? '0 : i_dividend;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ABS_A;
                    end
                end
            end
            ST_ABS_A: begin
                o_alu_b = quo_q;
                quo_d   = na_q ? i_alu_res : quo_q;
                state_d = ST_ABS_B;
            end
            ST_ABS_B: begin
                o_alu_b = dvs_q;
                dvs_d   = nb_q ? i_alu_res : dvs_q;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                // Restoring step; rem[MSB] shifted out acts as a 33rd bit
                sh      = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                o_alu_a = sh;
                o_alu_b = dvs_q;
                borrow  = (~sh[XLEN-1] & dvs_q[XLEN-1]) |
                          (~(sh[XLEN-1] ^ dvs_q[XLEN-1]) & i_alu_res[XLEN-1]);
                take    = rem_q[XLEN-1] | ~borrow;
                rem_d   = take ? i_alu_res : sh;
                quo_d   = {quo_q[XLEN-2:0], take};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                fix_val = is_rem_q ? rem_q : quo_q;
                fix_neg = is_rem_q ? na_q : (na_q ^ nb_q);
                o_alu_b = fix_val;
                res_d   = fix_neg ? i_alu_res : fix_val;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    // State, datapath and registered status/result outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            na_q     <= 1'b0;
            nb_q     <= 1'b0;
            is_rem_q <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_res    <= '0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            na_q     <= na_d;
            nb_q     <= nb_d;
            is_rem_q <= is_rem_d;
            o_busy   <= (state_d != ST_IDLE);
            o_done   <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                o_res <= res_d;
            end
        end
    end

endmodule
